// File: rtl/spi_slave_mux.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_mux
// Description : Parametrised SPI slave. Collects NUM_CFG configuration words
//               from MOSI for the register map, then serialises one selected
//               channel word or a burst of every channel on MISO. Supports
//               all four SPI modes and aborts on slave-select release.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_mux #(
  parameter int NUM_CH  = 3,
  parameter int DATA_W  = 16,
  parameter int CFG_W   = 8,
  parameter int NUM_CFG = 8,
  parameter int ADDR_W  = 3,
  parameter int CPOL    = 0,
  parameter int CPHA    = 0,
  parameter int SEL_W   = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sclk_in,
  input  logic                     mosi_in,
  input  logic                     ss_n_in,
  input  logic                     write_enable_in,
  input  logic                     burst_in,
  input  logic [SEL_W-1:0]         output_select_in,
  input  logic [NUM_CH*DATA_W-1:0] ch_data_in,
  output logic [CFG_W-1:0]         config_data_out,
  output logic [ADDR_W-1:0]        addr_out,
  output logic                     config_valid_out,
  output logic                     miso_out,
  output logic                     done_out,
  output logic                     configured_out,
  output logic                     data_ready_out,
  output logic                     abort_out
);

  localparam int c_CNT_MAX = (DATA_W > CFG_W) ? DATA_W : CFG_W;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

  typedef enum logic [1:0] {
    ST_CONFIG = 2'd0,
    ST_IDLE   = 2'd1,
    ST_SEND   = 2'd2
  } state_t;

  // Synchronisers and registered edge strobes
  logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
  logic mosi_meta_q, mosi_sync_q;
  logic ss_meta_q, ss_sync_q, ss_prev_q;
  logic sample_stb_q, shift_stb_q, ss_rise_q;

  // Control and datapath state
  state_t               state_q, state_d;
  logic [c_CNT_W-1:0]   cnt_q, cnt_d;
  logic [CFG_W-2:0]     cfg_sr_q, cfg_sr_d;
  logic [ADDR_W-1:0]    idx_q, idx_d;
  logic [CFG_W-1:0]     cfg_data_q, cfg_data_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic                 cfg_valid_q, cfg_valid_d;
  logic                 configured_q, configured_d;
  logic [DATA_W-1:0]    out_sr_q, out_sr_d;
  logic [SEL_W-1:0]     ch_q, ch_d;
  logic                 burst_q, burst_d;
  logic                 skip_q, skip_d;
  logic                 ready_q, ready_d;
  logic                 done_q, done_d;
  logic                 abort_q, abort_d;

  logic             w_sclk_rise, w_sclk_fall, w_lead, w_trail;
  logic             w_sample, w_shift, w_word_edge, w_last_ch;
  logic [CFG_W-1:0] w_cfg_word;

  // Channel mux; selects at or beyond NUM_CH read as zero
  function automatic logic [DATA_W-1:0] f_chan(input logic [NUM_CH*DATA_W-1:0] data,
                                               input int idx);
    f_chan = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (idx == k) f_chan = data[k*DATA_W +: DATA_W];
    end
  endfunction

  assign w_sclk_rise = sclk_sync_q & ~sclk_prev_q;
  assign w_sclk_fall = ~sclk_sync_q & sclk_prev_q;
  assign w_lead      = (CPOL != 0) ? w_sclk_fall : w_sclk_rise;
  assign w_trail     = (CPOL != 0) ? w_sclk_rise : w_sclk_fall;
  assign w_sample    = (CPHA != 0) ? w_trail : w_lead;
  assign w_shift     = (CPHA != 0) ? w_lead : w_trail;
  // With CPHA=1 a word ends on its last sample edge so the reload lands
  // before the next word's first (unapplied) shift edge.
  assign w_word_edge = (CPHA != 0) ? sample_stb_q : shift_stb_q;
  assign w_last_ch   = (int'(ch_q) >= NUM_CH - 1);
  assign w_cfg_word  = {cfg_sr_q, mosi_sync_q};

  // Two-flop synchronisers plus one-cycle edge strobes gated by slave select
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_meta_q  <= (CPOL != 0);
      sclk_sync_q  <= (CPOL != 0);
      sclk_prev_q  <= (CPOL != 0);
      mosi_meta_q  <= 1'b0;
      mosi_sync_q  <= 1'b0;
      ss_meta_q    <= 1'b1;
      ss_sync_q    <= 1'b1;
      ss_prev_q    <= 1'b1;
      sample_stb_q <= 1'b0;
      shift_stb_q  <= 1'b0;
      ss_rise_q    <= 1'b0;
    end else begin
      sclk_meta_q  <= sclk_in;
      sclk_sync_q  <= sclk_meta_q;
      sclk_prev_q  <= sclk_sync_q;
      mosi_meta_q  <= mosi_in;
      mosi_sync_q  <= mosi_meta_q;
      ss_meta_q    <= ss_n_in;
      ss_sync_q    <= ss_meta_q;
      ss_prev_q    <= ss_sync_q;
      sample_stb_q <= w_sample & ~ss_sync_q;
      shift_stb_q  <= w_shift & ~ss_sync_q;
      ss_rise_q    <= ss_sync_q & ~ss_prev_q;
    end
  end

  // Next-state logic for the CONFIG / IDLE / SEND controller and datapath
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cfg_sr_d     = cfg_sr_q;
    idx_d        = idx_q;
    cfg_data_d   = cfg_data_q;
    addr_d       = addr_q;
    cfg_valid_d  = 1'b0;
    configured_d = configured_q;
    out_sr_d     = out_sr_q;
    ch_d         = ch_q;
    burst_d      = burst_q;
    skip_d       = skip_q;
    ready_d      = ready_q;
    done_d       = 1'b0;
    abort_d      = 1'b0;
    unique case (state_q)
      ST_CONFIG: begin
        if (ss_rise_q && (cnt_q != '0)) begin
          // Partial word discarded; index is left alone
          abort_d  = 1'b1;
          cnt_d    = '0;
          cfg_sr_d = '0;
        end else if (sample_stb_q) begin
          cfg_sr_d = w_cfg_word[CFG_W-2:0];
          if (cnt_q == c_CNT_W'(CFG_W - 1)) begin
            cnt_d       = '0;
            cfg_data_d  = w_cfg_word;
            addr_d      = idx_q;
            cfg_valid_d = 1'b1;
            if (idx_q == ADDR_W'(NUM_CFG - 1)) begin
              configured_d = 1'b1;
              state_d      = ST_IDLE;
            end else begin
              idx_d = idx_q + ADDR_W'(1);
            end
          end else begin
            cnt_d = cnt_q + c_CNT_W'(1);
          end
        end
      end
      ST_IDLE: begin
        if (write_enable_in) begin
          out_sr_d = burst_in ? f_chan(ch_data_in, 0)
                              : f_chan(ch_data_in, int'(output_select_in));
          ch_d     = '0;
          burst_d  = burst_in;
          skip_d   = 1'b1;
          cnt_d    = '0;
          ready_d  = 1'b1;
          state_d  = ST_SEND;
        end
      end
      ST_SEND: begin
        if (ss_rise_q && (cnt_q != '0)) begin
          abort_d = 1'b1;
          cnt_d   = '0;
          ready_d = 1'b0;
          burst_d = 1'b0;
          state_d = ST_IDLE;
        end else begin
          if (shift_stb_q) begin
            if ((CPHA != 0) && skip_q) skip_d = 1'b0;
            else out_sr_d = {out_sr_q[DATA_W-2:0], 1'b0};
          end
          if (w_word_edge) begin
            if (cnt_q == c_CNT_W'(DATA_W - 1)) begin
              cnt_d = '0;
              if (burst_q && !w_last_ch) begin
                ch_d     = ch_q + SEL_W'(1);
                out_sr_d = f_chan(ch_data_in, int'(ch_q) + 1);
                skip_d   = 1'b1;
              end else begin
                done_d  = 1'b1;
                ready_d = 1'b0;
                burst_d = 1'b0;
                state_d = ST_IDLE;
              end
            end else begin
              cnt_d = cnt_q + c_CNT_W'(1);
            end
          end
        end
      end
      default: state_d = ST_CONFIG;
    endcase
  end

  // State register for the controller and datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_CONFIG;
      cnt_q        <= '0;
      cfg_sr_q     <= '0;
      idx_q        <= '0;
      cfg_data_q   <= '0;
      addr_q       <= '0;
      cfg_valid_q  <= 1'b0;
      configured_q <= 1'b0;
      out_sr_q     <= '0;
      ch_q         <= '0;
      burst_q      <= 1'b0;
      skip_q       <= 1'b0;
      ready_q      <= 1'b0;
      done_q       <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cfg_sr_q     <= cfg_sr_d;
      idx_q        <= idx_d;
      cfg_data_q   <= cfg_data_d;
      addr_q       <= addr_d;
      cfg_valid_q  <= cfg_valid_d;
      configured_q <= configured_d;
      out_sr_q     <= out_sr_d;
      ch_q         <= ch_d;
      burst_q      <= burst_d;
      skip_q       <= skip_d;
      ready_q      <= ready_d;
      done_q       <= done_d;
      abort_q      <= abort_d;
    end
  end

  assign config_data_out  = cfg_data_q;
  assign addr_out         = addr_q;
  assign config_valid_out = cfg_valid_q;
  assign miso_out         = out_sr_q[DATA_W-1];
  assign done_out         = done_q;
  assign configured_out   = configured_q;
  assign data_ready_out   = ready_q;
  assign abort_out        = abort_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_slave_mux
// Description : Scoreboard bench for spi_slave_mux. Instance 0 runs SPI
//               mode 0, instance 1 runs mode 3 (CPOL=1, CPHA=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave_mux;

  localparam int NUM_CH = 3;
  localparam int DATA_W = 16;
  localparam int CFG_W  = 8;
  localparam int NUM_CFG = 8;
  localparam int ADDR_W = 3;
  localparam int SEL_W  = 2;
  localparam int H      = 80;   // half SCLK period = 8 clk

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst     = 1'b1;
  logic [1:0]               sclk    = 2'b10;
  logic [1:0]               mosi    = 2'b00;
  logic [1:0]               ss_n    = 2'b11;
  logic [1:0]               we      = 2'b00;
  logic                     burst   = 1'b0;
  logic [SEL_W-1:0]         sel     = '0;
  logic [NUM_CH*DATA_W-1:0] ch_data = '0;

  wire [CFG_W-1:0]  cfg_data [2];
  wire [ADDR_W-1:0] addr     [2];
  wire [1:0]        cfg_valid, miso, done, configured, ready, abort;

  int checks   = 0;
  int failures = 0;

  // Scoreboard queues: {dut, addr, data} and {dut, word}
  logic [11:0] cfg_q  [$];
  logic [16:0] word_q [$];

  int         cfg_idx    [2] = '{0, 0};
  int         exp_bits   [2] = '{0, 0};
  int         done_cnt   [2] = '{0, 0};
  int         abort_cnt  [2] = '{0, 0};
  int         nbit       [2] = '{0, 0};
  int         frame_bits [2] = '{0, 0};
  logic [15:0] rx        [2] = '{16'h0, 16'h0};
  logic [1:0] mon_send  = 2'b00;
  logic [1:0] sclk_prev = 2'b10;

  spi_slave_mux #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CFG_W(CFG_W), .NUM_CFG(NUM_CFG),
                  .ADDR_W(ADDR_W), .CPOL(0), .CPHA(0)) u_dut_m0 (
    .clk(clk), .rst(rst), .sclk_in(sclk[0]), .mosi_in(mosi[0]), .ss_n_in(ss_n[0]),
    .write_enable_in(we[0]), .burst_in(burst), .output_select_in(sel), .ch_data_in(ch_data),
    .config_data_out(cfg_data[0]), .addr_out(addr[0]), .config_valid_out(cfg_valid[0]),
    .miso_out(miso[0]), .done_out(done[0]), .configured_out(configured[0]),
    .data_ready_out(ready[0]), .abort_out(abort[0]));

  spi_slave_mux #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CFG_W(CFG_W), .NUM_CFG(NUM_CFG),
                  .ADDR_W(ADDR_W), .CPOL(1), .CPHA(1)) u_dut_m3 (
    .clk(clk), .rst(rst), .sclk_in(sclk[1]), .mosi_in(mosi[1]), .ss_n_in(ss_n[1]),
    .write_enable_in(we[1]), .burst_in(burst), .output_select_in(sel), .ch_data_in(ch_data),
    .config_data_out(cfg_data[1]), .addr_out(addr[1]), .config_valid_out(cfg_valid[1]),
    .miso_out(miso[1]), .done_out(done[1]), .configured_out(configured[1]),
    .data_ready_out(ready[1]), .abort_out(abort[1]));

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  function automatic logic [63:0] outs(input int m);
    return {cfg_data[m], addr[m], cfg_valid[m], miso[m], done[m], configured[m],
            ready[m], abort[m]};
  endfunction

  // Reference: channel k's word, or zero for a non-existent channel
  function automatic logic [DATA_W-1:0] chan_word(input int k);
    logic [NUM_CH*DATA_W-1:0] d;
    d = ch_data;
    if (k < NUM_CH) return d[k*DATA_W +: DATA_W];
    return '0;
  endfunction

  // Monitor: reads MISO at each master sample edge (rising SCLK in both modes)
  // and checks config words, done timing and aborts against the scoreboard.
  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      automatic logic [15:0] nrx = rx[m];
      automatic int          nb  = nbit[m];
      automatic int          fb  = frame_bits[m];
      automatic logic [11:0] ec;
      automatic logic [16:0] ew;
      if (!mon_send[m]) begin
        nrx = '0; nb = 0; fb = 0;
      end else if (sclk[m] && !sclk_prev[m] && !ss_n[m]) begin
        nrx = {nrx[14:0], miso[m]};
        nb++;
        fb++;
        if (nb == DATA_W) begin
          nb = 0;
          if (word_q.size() == 0) fail_now("miso_unexpected_word");
          else begin
            ew = word_q.pop_front();
            check("miso_word", {47'd0, m[0], nrx}, {47'd0, ew});
          end
        end
      end
      rx[m]         <= nrx;
      nbit[m]       <= nb;
      frame_bits[m] <= fb;
      if (cfg_valid[m]) begin
        if (cfg_q.size() == 0) fail_now("config_valid_unexpected");
        else begin
          ec = cfg_q.pop_front();
          check("config_word", {52'd0, m[0], addr[m], cfg_data[m]}, {52'd0, ec});
        end
      end
      if (done[m]) begin
        done_cnt[m] <= done_cnt[m] + 1;
        check("done_after_bits", 64'(fb), 64'(exp_bits[m]));
      end
      if (abort[m]) abort_cnt[m] <= abort_cnt[m] + 1;
    end
    sclk_prev <= sclk;
  end

  // SPI master: MSB first; mode 0 on DUT 0, mode 3 on DUT 1
  task automatic xfer(input int m, input int nbits, input logic [63:0] bits, input bit end_frame);
    ss_n[m] = 1'b0;
    #(H);
    for (int i = 0; i < nbits; i++) begin
      if (m == 0) begin
        mosi[m] = bits[nbits-1-i];
        #(H) sclk[m] = 1'b1;
        #(H) sclk[m] = 1'b0;
      end else begin
        sclk[m] = 1'b0;
        mosi[m] = bits[nbits-1-i];
        #(H) sclk[m] = 1'b1;
        #(H);
      end
    end
    #(H);
    if (end_frame) begin
      ss_n[m] = 1'b1;
      #(200);
    end
  endtask

  task automatic cfg_byte(input int m, input logic [7:0] b);
    cfg_q.push_back({m[0], 3'(cfg_idx[m]), b});
    cfg_idx[m]++;
    xfer(m, 8, {56'd0, b}, 1'b1);
  endtask

  task automatic load(input int m, input logic b, input logic [SEL_W-1:0] s);
    @(posedge clk);
    #1 burst = b; sel = s; we[m] = 1'b1;
    @(posedge clk);
    #1 we[m] = 1'b0;
    check("data_ready_rise", 64'(ready[m]), 64'd1);
  endtask

  // One output frame; the reference predicts the word list from the request
  task automatic frame(input int m, input logic b, input logic [SEL_W-1:0] s, input bit interfere);
    int nw;
    int d0;
    nw = b ? NUM_CH : 1;
    for (int w = 0; w < nw; w++)
      word_q.push_back({m[0], b ? chan_word(w) : chan_word(int'(s))});
    exp_bits[m] = nw * DATA_W;
    d0 = done_cnt[m];
    load(m, b, s);
    mon_send[m] = 1'b1;
    if (interfere) begin
      fork
        xfer(m, nw * DATA_W, 64'd0, 1'b1);
        begin
          repeat (60) @(posedge clk);
          #1 burst = ~b; sel = s + 2'd1; we[m] = 1'b1;
          @(posedge clk);
          #1 we[m] = 1'b0;
        end
      join
    end else begin
      xfer(m, nw * DATA_W, 64'd0, 1'b1);
    end
    mon_send[m] = 1'b0;
    check("done_count", 64'(done_cnt[m]), 64'(d0 + 1));
    check("data_ready_fall", 64'(ready[m]), 64'd0);
    check("words_left", 64'(word_q.size()), 64'd0);
  endtask

  task automatic rand_ch();
    ch_data = {16'($urandom), 16'($urandom), 16'($urandom)};
  endtask

  initial begin
    #(800_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int d0;
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("reset_outputs_m0", outs(0), 64'd0);
    check("reset_outputs_m1", outs(1), 64'd0);
    rst = 1'b0;
    repeat (5) @(posedge clk);

    // Mode 0 configuration with an aborted partial byte after word 2
    for (int i = 0; i < 3; i++) cfg_byte(0, 8'hA0 + 8'(i));
    a0 = abort_cnt[0];
    xfer(0, 5, 64'($urandom), 1'b1);
    check("config_abort_pulse", 64'(abort_cnt[0]), 64'(a0 + 1));
    check("configured_m0_early", 64'(configured[0]), 64'd0);
    for (int i = 3; i < NUM_CFG; i++) begin
      cfg_byte(0, 8'hA0 + 8'(i));
      if (i == NUM_CFG - 2) check("configured_m0_before_last", 64'(configured[0]), 64'd0);
    end
    check("configured_m0", 64'(configured[0]), 64'd1);

    // Mode 3 configuration with random bytes
    for (int i = 0; i < NUM_CFG; i++) cfg_byte(1, 8'($urandom));
    check("configured_m1", 64'(configured[1]), 64'd1);

    // Directed frames on mode 0
    ch_data = {16'h9ABC, 16'hBEEF, 16'h1234};
    frame(0, 1'b0, 2'd1, 1'b0);
    ch_data = {16'h9ABC, 16'h5678, 16'h1234};
    frame(0, 1'b1, 2'd0, 1'b0);
    frame(0, 1'b0, 2'd3, 1'b0);
    frame(0, 1'b0, 2'd2, 1'b1);

    // Randomised frames on mode 0
    for (int i = 0; i < 6; i++) begin
      rand_ch();
      frame(0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b0);
    end

    // Abort an output word after five bits
    rand_ch();
    load(0, 1'b0, 2'd2);
    a0 = abort_cnt[0];
    d0 = done_cnt[0];
    xfer(0, 5, 64'd0, 1'b1);
    check("send_abort_pulse", 64'(abort_cnt[0]), 64'(a0 + 1));
    check("send_abort_no_done", 64'(done_cnt[0]), 64'(d0));
    check("send_abort_ready", 64'(ready[0]), 64'd0);

    // Mode 3: same single load, then random frames including bursts
    ch_data = {16'h9ABC, 16'hBEEF, 16'h1234};
    frame(1, 1'b0, 2'd1, 1'b0);
    ch_data = {16'h9ABC, 16'h5678, 16'h1234};
    frame(1, 1'b1, 2'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      rand_ch();
      frame(1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b0);
    end

    // Reset in the middle of a burst
    rand_ch();
    load(0, 1'b1, 2'd0);
    xfer(0, 20, 64'd0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("reset_mid_burst_outputs", outs(0), 64'd0);
    rst = 1'b0;
    ss_n[0] = 1'b1;
    repeat (20) @(posedge clk);

    check("config_queue_drained", 64'(cfg_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
